// File: rtl/game_score_ctrl.sv
// Game score controller: run/pause/over state machine, BCD score with prescaled
// game-time ticks, best-score tracking and an auto-advancing, adjustable level.
module game_score_ctrl #(
    parameter int SCORE_DIGITS    = 4,
    parameter int TICKS_PER_POINT = 6,
    parameter int LEVEL_PTS       = 100,
    parameter int LEVEL_MAX       = 9
) (
    input  logic                      clk,
    input  logic                      clr,
    input  logic                      tick_en,
    input  logic                      pause,
    input  logic                      start,
    input  logic                      hit,
    input  logic                      adj,
    input  logic [2:0]                num,
    output logic [4*SCORE_DIGITS-1:0] score_bcd,
    output logic [4*SCORE_DIGITS-1:0] hiscore_bcd,
    output logic [7:0]                level_bcd,
    output logic [1:0]                state
);

    localparam int SW = 4 * SCORE_DIGITS;
    localparam int PW = (TICKS_PER_POINT > 1) ? $clog2(TICKS_PER_POINT) : 1;
    localparam int CW = (LEVEL_PTS > 1) ? $clog2(LEVEL_PTS) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_POINT - 1);
    localparam logic [CW-1:0] PTS_LAST   = CW'(LEVEL_PTS - 1);
    localparam logic [6:0]    LVL_MAX    = 7'(LEVEL_MAX);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_PAUSED = 2'd2,
        S_OVER   = 2'd3
    } state_e;

    state_e          state_q;
    logic [SW-1:0]   score_q;
    logic [SW-1:0]   hiscore_q;
    logic [SW-1:0]   score_inc_d;
    logic [6:0]      level_q;
    logic [6:0]      level_inc_d;
    logic [6:0]      level_adj_d;
    logic [7:0]      level_bcd_q;
    logic [PW-1:0]   presc_q;
    logic [CW-1:0]   pts_q;
    logic            pause_q;
    logic            armed_q;
    logic            pause_edge;
    logic [SCORE_DIGITS:0] carry;

    function automatic logic [7:0] to_bcd(input logic [6:0] v);
        logic [3:0] tens;
        logic [3:0] ones;
        tens = 4'd0;
        ones = v[3:0];
        for (int t = 1; t < 10; t++) begin
            if (v >= 7'(t * 10)) begin
                tens = 4'(t);
                ones = 4'(v - 7'(t * 10));
            end
        end
        return {tens, ones};
    endfunction

    // Ripple-carry BCD increment; carry out of the top digit means all nines, so hold.
    assign carry[0] = 1'b1;
    genvar gi;
    generate
        for (gi = 0; gi < SCORE_DIGITS; gi++) begin : g_digit
            logic [3:0] dig;
            assign dig            = score_q[4*gi +: 4];
            assign carry[gi+1]    = carry[gi] & (dig == 4'd9);
            assign score_inc_d[4*gi +: 4] =
                (carry[SCORE_DIGITS] || !carry[gi]) ? dig :
                (dig == 4'd9)                       ? 4'd0 : dig + 4'd1;
        end
    endgenerate

    assign level_inc_d = (level_q >= LVL_MAX) ? LVL_MAX : level_q + 7'd1;
    assign level_adj_d = (num == 3'd0)            ? 7'd1    :
                         ({4'd0, num} > LVL_MAX)  ? LVL_MAX : {4'd0, num};

    // armed_q masks the first sample after reset so a pause already held high is not an edge.
    assign pause_edge = pause & ~pause_q & armed_q;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q     <= S_IDLE;
            score_q     <= '0;
            hiscore_q   <= '0;
            level_q     <= 7'd1;
            level_bcd_q <= 8'h01;
            presc_q     <= '0;
            pts_q       <= '0;
            pause_q     <= 1'b0;
            armed_q     <= 1'b0;
        end else begin
            pause_q <= pause;
            armed_q <= 1'b1;
            case (state_q)
                S_IDLE, S_OVER: begin
                    if (start) begin
                        state_q <= S_RUN;
                        score_q <= '0;
                        presc_q <= '0;
                        pts_q   <= '0;
                    end
                    if (adj && state_q == S_IDLE) begin
                        level_q     <= level_adj_d;
                        level_bcd_q <= to_bcd(level_adj_d);
                    end
                end
                S_RUN: begin
                    if (hit) begin
                        state_q <= S_OVER;
                        if (score_q > hiscore_q) begin
                            hiscore_q <= score_q;
                        end
                    end else if (pause_edge) begin
                        state_q <= S_PAUSED;
                    end else if (tick_en) begin
                        if (presc_q == PRESC_LAST) begin
                            presc_q <= '0;
                            score_q <= score_inc_d;
                            if (pts_q == PTS_LAST) begin
                                pts_q       <= '0;
                                level_q     <= level_inc_d;
                                level_bcd_q <= to_bcd(level_inc_d);
                            end else begin
                                pts_q <= pts_q + CW'(1);
                            end
                        end else begin
                            presc_q <= presc_q + PW'(1);
                        end
                    end
                end
                S_PAUSED: begin
                    if (pause_edge) begin
                        state_q <= S_RUN;
                    end
                    if (adj) begin
                        level_q     <= level_adj_d;
                        level_bcd_q <= to_bcd(level_adj_d);
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign score_bcd   = score_q;
    assign hiscore_bcd = hiscore_q;
    assign level_bcd   = level_bcd_q;
    assign state       = state_q;

endmodule

// File: tb/tb_game_score_ctrl.sv
// Bench for game_score_ctrl: integer reference model feeds a scoreboard, plus
// directed scenario tasks with fixed expected values.
module tb_game_score_ctrl;

    localparam int TPP = 2;
    localparam int SD  = 2;
    localparam int LP  = 3;
    localparam int LM  = 3;

    logic       clk = 1'b0;
    logic       clr = 1'b1;
    logic       tick_en = 1'b0;
    logic       pause = 1'b0;
    logic       start = 1'b0;
    logic       hit = 1'b0;
    logic       adj = 1'b0;
    logic [2:0] num = 3'd0;
    logic [7:0] score_bcd;
    logic [7:0] hiscore_bcd;
    logic [7:0] level_bcd;
    logic [1:0] state;

    always #5 clk = ~clk;

    game_score_ctrl #(
        .SCORE_DIGITS(SD), .TICKS_PER_POINT(TPP), .LEVEL_PTS(LP), .LEVEL_MAX(LM)
    ) dut (
        .clk(clk), .clr(clr), .tick_en(tick_en), .pause(pause), .start(start),
        .hit(hit), .adj(adj), .num(num), .score_bcd(score_bcd),
        .hiscore_bcd(hiscore_bcd), .level_bcd(level_bcd), .state(state)
    );

    typedef struct {
        logic [25:0] v;
        string       tag;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   txn = 0;

    int   m_st, m_sc, m_hi, m_lv, m_ps, m_lp;
    logic m_pp;

    function automatic logic [7:0] to_bcd2(input int v);
        return 8'(((v / 10) % 10) * 16 + (v % 10));
    endfunction

    function automatic int clamp_lvl(input int n);
        if (n == 0) return 1;
        if (n > LM) return LM;
        return n;
    endfunction

    task automatic model_reset();
        m_st = 0; m_sc = 0; m_hi = 0; m_lv = 1; m_ps = 0; m_lp = 0;
        m_pp = pause;
    endtask

    // One transaction: drive inputs at negedge, advance the model, queue the expectation.
    task automatic step(input logic t, input logic p, input logic s, input logic h,
                        input logic a, input logic [2:0] n, input string tag);
        exp_t e;
        logic pe;
        @(negedge clk);
        tick_en = t; pause = p; start = s; hit = h; adj = a; num = n;
        pe   = p && !m_pp;
        m_pp = p;
        case (m_st)
            0, 3: begin
                if (s) begin
                    m_st = 1; m_sc = 0; m_ps = 0; m_lp = 0;
                end
                if (a && m_st == 0) m_lv = clamp_lvl(int'(n));
            end
            1: begin
                if (h) begin
                    m_st = 3;
                    if (m_sc > m_hi) m_hi = m_sc;
                end else if (pe) begin
                    m_st = 2;
                end else if (t) begin
                    m_ps++;
                    if (m_ps == TPP) begin
                        m_ps = 0;
                        if (m_sc < 99) m_sc++;
                        m_lp++;
                        if (m_lp == LP) begin
                            m_lp = 0;
                            if (m_lv < LM) m_lv++;
                        end
                    end
                end
            end
            default: begin
                if (pe) m_st = 1;
                if (a) m_lv = clamp_lvl(int'(n));
            end
        endcase
        e.v   = {2'(m_st), to_bcd2(m_sc), to_bcd2(m_hi), to_bcd2(m_lv)};
        e.tag = tag;
        sb_q.push_back(e);
        @(posedge clk);
        #3;
        tick_en = 1'b0; start = 1'b0; hit = 1'b0; adj = 1'b0;
    endtask

    always @(posedge clk) begin
        exp_t        e;
        logic [25:0] act;
        #2;
        if (sb_q.size() > 0) begin
            e   = sb_q.pop_front();
            act = {state, score_bcd, hiscore_bcd, level_bcd};
            txn++;
            checks++;
            if (act !== e.v) begin
                errors++;
                $display("FAIL sb_%s: got st=%0d sc=%h hi=%h lv=%h want st=%0d sc=%h hi=%h lv=%h",
                         e.tag, act[25:24], act[23:16], act[15:8], act[7:0],
                         e.v[25:24], e.v[23:16], e.v[15:8], e.v[7:0]);
            end else begin
                $display("txn %0d %s st=%0d sc=%h hi=%h lv=%h",
                         txn, e.tag, act[25:24], act[23:16], act[15:8], act[7:0]);
            end
        end
    end

    task automatic release_clr();
        @(negedge clk);
        clr = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #3;
        checks++;
        if ({state, score_bcd, hiscore_bcd, level_bcd} !== 26'h0000001) begin
            errors++;
            $display("FAIL reset_values: got st=%0d sc=%h hi=%h lv=%h want st=0 sc=00 hi=00 lv=01",
                     state, score_bcd, hiscore_bcd, level_bcd);
        end
        release_clr();
    endtask

    task automatic test_score_level();
        step(0, 0, 1, 0, 0, 3'd0, "start");
        repeat (6) step(1, 0, 0, 0, 0, 3'd0, "tick");
        checks++;
        if (score_bcd !== 8'h03 || level_bcd !== 8'h02) begin
            errors++;
            $display("FAIL six_ticks: got sc=%h lv=%h want sc=03 lv=02", score_bcd, level_bcd);
        end
        repeat (14) step(1, 0, 0, 0, 0, 3'd0, "tick");
        checks++;
        if (level_bcd !== 8'h03 || score_bcd !== 8'h10) begin
            errors++;
            $display("FAIL level_sat: got sc=%h lv=%h want sc=10 lv=03", score_bcd, level_bcd);
        end
        repeat (178) step(1, 0, 0, 0, 0, 3'd0, "tick");
        checks++;
        if (score_bcd !== 8'h99) begin
            errors++;
            $display("FAIL score_99: got %h want 99", score_bcd);
        end
        repeat (2) step(1, 0, 0, 0, 0, 3'd0, "tick_sat");
        checks++;
        if (score_bcd !== 8'h99) begin
            errors++;
            $display("FAIL score_saturate: got %h want 99", score_bcd);
        end
    endtask

    task automatic test_pause_adj();
        step(0, 1, 0, 0, 0, 3'd0, "pause_edge");
        checks++;
        if (state !== 2'd2) begin
            errors++;
            $display("FAIL pause_enter: got state %0d want 2", state);
        end
        repeat (4) step(1, 1, 0, 0, 0, 3'd0, "tick_paused");
        step(0, 0, 0, 0, 1, 3'd0, "adj_num0");
        checks++;
        if (score_bcd !== 8'h99 || level_bcd !== 8'h01 || state !== 2'd2) begin
            errors++;
            $display("FAIL paused_adj: got sc=%h lv=%h st=%0d want sc=99 lv=01 st=2",
                     score_bcd, level_bcd, state);
        end
        step(0, 1, 0, 0, 0, 3'd0, "resume_edge");
        checks++;
        if (state !== 2'd1) begin
            errors++;
            $display("FAIL pause_exit: got state %0d want 1", state);
        end
    endtask

    task automatic test_async_clr();
        step(0, 1, 0, 1, 0, 3'd0, "hit_99");
        step(0, 1, 1, 0, 0, 3'd0, "restart");
        repeat (3) step(1, 1, 0, 0, 0, 3'd0, "tick");
        #1;
        clr = 1'b1;
        #1;
        checks++;
        if ({state, score_bcd, hiscore_bcd, level_bcd} !== 26'h0000001) begin
            errors++;
            $display("FAIL async_clr: got st=%0d sc=%h hi=%h lv=%h want st=0 sc=00 hi=00 lv=01",
                     state, score_bcd, hiscore_bcd, level_bcd);
        end
        release_clr();
    endtask

    task automatic test_hit_hiscore();
        step(0, 1, 1, 0, 0, 3'd0, "start_pause_high");
        repeat (10) step(1, 1, 0, 0, 0, 3'd0, "tick");
        checks++;
        if (score_bcd !== 8'h05 || state !== 2'd1) begin
            errors++;
            $display("FAIL score_05: got sc=%h st=%0d want sc=05 st=1", score_bcd, state);
        end
        step(1, 0, 0, 1, 0, 3'd0, "hit_with_tick");
        checks++;
        if (state !== 2'd3 || hiscore_bcd !== 8'h05 || score_bcd !== 8'h05) begin
            errors++;
            $display("FAIL hit_tick: got st=%0d hi=%h sc=%h want st=3 hi=05 sc=05",
                     state, hiscore_bcd, score_bcd);
        end
        step(1, 1, 0, 1, 0, 3'd0, "hit_in_over");
        step(0, 0, 1, 0, 0, 3'd0, "start_again");
        repeat (4) step(1, 0, 0, 0, 0, 3'd0, "tick");
        step(0, 0, 0, 1, 0, 3'd0, "hit_low");
        checks++;
        if (hiscore_bcd !== 8'h05 || score_bcd !== 8'h02) begin
            errors++;
            $display("FAIL hiscore_keep: got hi=%h sc=%h want hi=05 sc=02", hiscore_bcd, score_bcd);
        end
    endtask

    task automatic test_adj_level();
        #1;
        clr = 1'b1;
        release_clr();
        step(0, 0, 0, 0, 1, 3'd7, "adj7_idle");
        checks++;
        if (level_bcd !== 8'h03) begin
            errors++;
            $display("FAIL adj_clamp: got %h want 03", level_bcd);
        end
        step(0, 0, 1, 0, 0, 3'd0, "start");
        step(1, 0, 0, 0, 1, 3'd1, "adj_in_run");
        checks++;
        if (level_bcd !== 8'h03) begin
            errors++;
            $display("FAIL adj_ignored_run: got %h want 03", level_bcd);
        end
        step(1, 0, 1, 0, 0, 3'd0, "start_in_run");
        checks++;
        if (score_bcd !== 8'h01) begin
            errors++;
            $display("FAIL start_ignored_run: got %h want 01", score_bcd);
        end
        step(0, 0, 0, 1, 0, 3'd0, "hit");
        step(0, 0, 0, 0, 1, 3'd2, "adj_in_over");
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 300; i++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
                 1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 15) == 0),
                 1'($urandom_range(0, 7) == 0), 3'($urandom_range(0, 7)), "rand");
        end
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: got %0d pending want 0", sb_q.size());
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_score_level();
        test_pause_adj();
        test_async_clr();
        test_hit_hiscore();
        test_adj_level();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
